// File: rtl/drum_step_scheduler_pkg.sv
// Shared definitions for the drum membrane step scheduler.
// Holds the scheduler state encoding and the 1.17 fixed-point widths used by
// both the scheduler and the column compute datapath.
package drum_step_scheduler_pkg;

  // 1.17 unsigned rho: one integer bit, seventeen fraction bits.
  localparam int FRAC_W = 17;
  localparam int INT_W  = 1;
  localparam int RHO_W  = INT_W + FRAC_W;

  // Signed membrane node amplitude width.
  localparam int AMP_W  = 18;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    INIT_WAIT = 3'd2,
    WAIT_TICK = 3'd3,
    START     = 3'd4,
    RUN       = 3'd5,
    CAPTURE   = 3'd6,
    OUTPUT    = 3'd7
  } state_t;

endpackage

// File: rtl/drum_step_scheduler_done_collector.sv
// Sticky completion mask across all column engines.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   clear         empties the mask (takes priority over enable)
//   enable        accumulate done pulses this cycle; when low they are ignored
//   done          per-column one-cycle completion pulses
//   all_done      every column has reported, counting this cycle's pulses
module drum_step_scheduler_done_collector
  import drum_step_scheduler_pkg::*;
#(
  parameter int NUM_COL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [NUM_COL-1:0] done,
  output logic               all_done
);

  logic [NUM_COL-1:0] mask;
  logic [NUM_COL-1:0] mask_next;

  // A repeated done for an already-reported column simply ORs in again.
  assign mask_next = mask | (enable ? done : '0);

  // Includes the current cycle's pulses so the scheduler leaves the wait
  // state in the same cycle the last column reports.
  assign all_done = enable && (&mask_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
    end else if (clear) begin
      mask <= '0;
    end else begin
      mask <= mask_next;
    end
  end

endmodule

// File: rtl/drum_step_scheduler.sv
// Per-sample step sequencer for the finite-difference drum membrane.
// On each audio sample tick it latches rho, pulses start to every column
// engine, waits for all columns to finish, captures the centre-node amplitude
// and offers it to the audio path over valid/ready. It also runs membrane
// re-initialisation at power-up and on request, between steps.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   sample_tick     one-cycle pulse per audio sample
//   init_req        one-cycle request to reload the membrane initial profile
//   rho_in/rho_out  1.17 rho in, and the copy held for the running step
//   col_init        one-cycle pulse: columns reload their initial profile
//   col_start       one-cycle pulse: columns perform one traversal
//   col_done        per-column completion pulses
//   node_amp_in     centre-node amplitude, valid the cycle after the last done
//   audio_data/audio_valid/audio_ready  output sample handshake
//   busy            high while initialising or stepping
//   overrun         sticky: a sample tick was dropped
//   step_count      completed steps, wrapping
module drum_step_scheduler
  import drum_step_scheduler_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int STEP_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic                    init_req,
  input  logic [RHO_W-1:0]        rho_in,
  output logic [RHO_W-1:0]        rho_out,
  output logic [NUM_COL-1:0]      col_init,
  output logic [NUM_COL-1:0]      col_start,
  input  logic [NUM_COL-1:0]      col_done,
  input  logic signed [AMP_W-1:0] node_amp_in,
  output logic signed [AMP_W-1:0] audio_data,
  output logic                    audio_valid,
  input  logic                    audio_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [STEP_CNT_W-1:0]   step_count
);

  state_t state;
  state_t state_next;

  logic tick_pend;
  logic tick_pend_next;
  logic init_pend;
  logic init_pend_next;
  logic overrun_next;
  logic tick_absorb;
  logic mask_clear;
  logic mask_en;
  logic all_done;

  drum_step_scheduler_done_collector #(
    .NUM_COL (NUM_COL)
  ) u_done_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (mask_clear),
    .enable   (mask_en),
    .done     (col_done),
    .all_done (all_done)
  );

  // A tick is parked whenever it cannot start a step right now, including
  // the case where a pending or simultaneous init wins in WAIT_TICK.
  assign tick_absorb = sample_tick &&
                       ((state != WAIT_TICK) || init_pend || init_req);

  always_comb begin
    state_next     = state;
    tick_pend_next = tick_pend;
    init_pend_next = init_pend;
    overrun_next   = overrun;
    mask_clear     = 1'b0;
    mask_en        = 1'b0;

    // Only one tick can be held; a second one is lost and flagged.
    if (tick_absorb) begin
      if (tick_pend) begin
        overrun_next = 1'b1;
      end else begin
        tick_pend_next = 1'b1;
      end
    end

    // Init requests never abort a step; they are remembered until WAIT_TICK.
    if (init_req && (state != WAIT_TICK) && (state != IDLE)) begin
      init_pend_next = 1'b1;
    end

    case (state)
      IDLE: begin
        state_next = INIT;
      end
      INIT: begin
        mask_clear = 1'b1;
        state_next = INIT_WAIT;
      end
      INIT_WAIT: begin
        mask_en = 1'b1;
        if (all_done) begin
          state_next     = WAIT_TICK;
          init_pend_next = 1'b0;
        end
      end
      WAIT_TICK: begin
        if (init_pend || init_req) begin
          state_next = INIT;
        end else if (sample_tick || tick_pend) begin
          state_next = START;
          // Serving a parked tick while a fresh one arrives keeps the fresh
          // one parked rather than silently losing it.
          tick_pend_next = tick_pend && sample_tick;
        end
      end
      START: begin
        mask_clear = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        mask_en = 1'b1;
        if (all_done) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        if (audio_ready) begin
          state_next = WAIT_TICK;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is registered from the next-state decision so that the
  // column pulses line up with the cycle spent in INIT/START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_pend   <= 1'b0;
      init_pend   <= 1'b0;
      overrun     <= 1'b0;
      col_init    <= '0;
      col_start   <= '0;
      busy        <= 1'b0;
      audio_valid <= 1'b0;
      audio_data  <= '0;
      rho_out     <= '0;
      step_count  <= '0;
    end else begin
      state       <= state_next;
      tick_pend   <= tick_pend_next;
      init_pend   <= init_pend_next;
      overrun     <= overrun_next;
      col_init    <= {NUM_COL{state_next == INIT}};
      col_start   <= {NUM_COL{state_next == START}};
      busy        <= (state_next != WAIT_TICK) && (state_next != IDLE);
      audio_valid <= (state_next == OUTPUT);
      // rho is frozen for the whole traversal.
      if ((state == WAIT_TICK) && (state_next == START)) begin
        rho_out <= rho_in;
      end
      if (state == CAPTURE) begin
        audio_data <= node_amp_in;
        step_count <= step_count + STEP_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/drum_step_scheduler.md
Name: drum_step_scheduler

Overview:
- Sequences the per-column membrane engines through one finite-difference time step per audio sample.
- Pulses start to all columns, collects their done pulses, and captures the centre-node amplitude.
- Hands the amplitude to the audio output path over a valid/ready handshake.
- Also controls membrane re-initialisation and latches rho once per step, so rho cannot change mid-traversal.

Parameters:
- NUM_COL, 4, number of column engines sequenced (1..32).
- STEP_CNT_W, 32, width of the completed-step counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse per audio sample, already synchronous to clk.
- init_req  in  1  one-cycle pulse requesting membrane re-initialisation.
- rho_in  in  18  rho, 1.17 unsigned.
- rho_out  out  18  rho latched for the current step.
- col_init  out  NUM_COL  one-cycle pulse: columns reload their initial profile.
- col_start  out  NUM_COL  one-cycle pulse: columns perform one full row traversal.
- col_done  in  NUM_COL  per-column one-cycle completion pulse (init or step).
- node_amp_in  in  18 signed  centre-node u_np1, valid in the cycle after the last done.
- audio_data  out  18 signed  captured amplitude.
- audio_valid  out  1  audio_data is valid.
- audio_ready  in  1  sink accepts audio_data.
- busy  out  1  high in any state except WAIT_TICK and IDLE.
- overrun  out  1  sticky: a sample tick was lost.
- step_count  out  STEP_CNT_W  number of completed steps; wraps.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: rho_out, col_init, col_start, audio_data, audio_valid, busy, overrun, step_count.
  - done_mask=0, tick_pend=0, init_pend=0.
- All outputs are registered.
- States:
  - IDLE: unconditionally go to INIT next cycle (power-up init).
  - INIT: col_init = all ones for exactly one cycle; clear done_mask; go to INIT_WAIT.
  - INIT_WAIT: done_mask |= col_done. When done_mask is all ones, go to WAIT_TICK and clear init_pend.
  - WAIT_TICK:
    - If init_pend, go to INIT (init has priority over ticks).
    - Else if sample_tick or tick_pend: clear tick_pend, rho_out<=rho_in, go to START.
  - START: col_start = all ones for exactly one cycle; clear done_mask; go to RUN.
  - RUN: done_mask |= col_done. When all ones, go to CAPTURE.
  - CAPTURE: audio_data<=node_amp_in; audio_valid<=1; step_count++; go to OUTPUT.
  - OUTPUT: hold audio_data and audio_valid stable. On audio_valid&&audio_ready, drop valid and go to WAIT_TICK.
- Tick timing: a tick sampled at edge k in WAIT_TICK gives col_start high during cycle k+1 and rho_out updated at edge k.
- Minimum step latency, tick to audio_valid: 3 cycles + slowest column traversal.
- Tick in any state other than WAIT_TICK:
  - If tick_pend=0, set tick_pend=1.
  - Else set overrun=1 and drop the tick; only one pending tick is held.
  - overrun clears only on reset.
- init_req in any state other than WAIT_TICK/IDLE sets init_pend. It never aborts a running step; it is serviced at the next WAIT_TICK.
- init_req arriving in WAIT_TICK together with sample_tick: init wins and the tick goes to tick_pend.
- Done handling:
  - A col_done bit for a column already set in done_mask is ignored.
  - col_done in WAIT_TICK, START, CAPTURE or OUTPUT is ignored.
  - col_done coincident with col_start (START cycle) is ignored.
- step_count wraps from all ones to 0 silently.
- A reset assertion mid-step forces IDLE immediately. Columns are re-initialised after release.

Decomposition:
- Shared package holds:
  - 3-bit state encodings IDLE, INIT, INIT_WAIT, WAIT_TICK, START, RUN, CAPTURE, OUTPUT.
  - The 18-bit amplitude/rho widths.
  - 1.17 format constants shared with the compute datapath.
- One natural sub-module: done_collector. It is a NUM_COL-wide sticky mask with a clear input, an enable input and an all_done output, and is reused in INIT_WAIT and RUN.

Test Plan:
- Power-up: release rst; col_init pulses once; all done bits return after 10 cycles → WAIT_TICK, busy=0, step_count=0.
- Single step: rho_in=18'h01000, tick; columns done at +40/+45/+50/+55 cycles; node_amp_in=18'h00C00; audio_ready=1 → col_start one cycle after tick, rho_out=18'h01000, audio_data=18'h00C00, step_count=1.
- Backpressure: audio_ready=0 for 20 cycles → audio_valid and audio_data held constant; accepted on the first ready cycle; state returns to WAIT_TICK.
- Overrun: three ticks during one RUN → first is pending and a second step starts right after OUTPUT; overrun=1; step_count=2 after both steps.
- init_req during RUN → current step completes and audio is emitted, then col_init pulses before any further col_start.
- Duplicate and stray done: col 0 done twice and a done in WAIT_TICK → no early CAPTURE; CAPTURE only after cols 1..3 done.
- Async reset mid-RUN → all outputs 0 immediately without a clock edge; the init sequence repeats after release.
